// File: rtl/puf_pkg.sv
// Shared definitions for the PUF challenge sequencer: FSM states, retry limit and vote sizing.
// Used by puf_seq and puf_vote.
package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_VOTE,
      ST_EMIT,
      ST_FIN
   } puf_state_e;

   localparam int RETRY_MAX = 3;
   localparam int RETRY_W   = 2;
   localparam int VOTE_W    = 3;
   localparam int RESP_W    = 6;

endpackage

// File: rtl/puf_seq_if.sv
// Handshake bundle between the challenge sequencer (master) and the PUF engine (slave).
interface puf_seq_if;

   logic        puf_req_o;
   logic [31:0] puf_sel_o;
   logic [3:0]  puf_wait_cyc_o;
   logic        puf_busy_i;
   logic        puf_valid_i;
   logic [5:0]  puf_q_i;
   logic [5:0]  puf_qn_i;

   modport master (
      output puf_req_o, puf_sel_o, puf_wait_cyc_o,
      input  puf_busy_i, puf_valid_i, puf_q_i, puf_qn_i
   );

   modport slave (
      input  puf_req_o, puf_sel_o, puf_wait_cyc_o,
      output puf_busy_i, puf_valid_i, puf_q_i, puf_qn_i
   );

endinterface

// File: rtl/puf_vote.sv
// Six per-bit vote counters with majority and (PUF_SEQ_STABILITY_EN) stability compare.
// Clear has priority over accumulate; compares use the counters' current contents.
module puf_vote
   import puf_pkg::*;
(
   input  logic              clk50,
   input  logic              rstn_clk50,
   input  logic              clr_i,
   input  logic              acc_i,
   input  logic [RESP_W-1:0] bits_i,
   input  logic [VOTE_W-1:0] reps_i,
`ifdef PUF_SEQ_STABILITY_EN
   output logic [RESP_W-1:0] unstable_o,
`endif
   output logic [RESP_W-1:0] maj_o
);

   logic [RESP_W-1:0][VOTE_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < RESP_W; i++) begin
         if (clr_i) begin
            cnt_d[i] = '0;
         end else if (acc_i) begin
            cnt_d[i] = cnt_q[i] + VOTE_W'(bits_i[i]);
         end
      end
   end

   always_ff @(posedge clk50 or negedge rstn_clk50) begin
      if (!rstn_clk50) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A bit wins when more than half of the evaluations voted for it.
   always_comb begin
      maj_o = '0;
      for (int i = 0; i < RESP_W; i++) begin
         maj_o[i] = {cnt_q[i], 1'b0} > {1'b0, reps_i};
      end
   end

`ifdef PUF_SEQ_STABILITY_EN
   always_comb begin
      unstable_o = '0;
      for (int i = 0; i < RESP_W; i++) begin
         unstable_o[i] = (cnt_q[i] != '0) && (cnt_q[i] != reps_i);
      end
   end
`endif

endmodule

// File: rtl/puf_seq.sv
// PUF challenge sequencer: issues challenges, retries bad samples, majority-votes responses.
// Optional unstable_o output enabled by defining PUF_SEQ_STABILITY_EN.
module puf_seq
   import puf_pkg::*;
#(
   parameter int NCHAL_W = 4,
   parameter int TMO_CYC = 64
)
(
   input  logic               clk50,
   input  logic               rstn_clk50,
   input  logic               start_i,
   input  logic [31:0]        base_sel_i,
   input  logic [NCHAL_W-1:0] num_chal_i,
   input  logic [2:0]         reps_i,
   input  logic [3:0]         wait_cyc_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic               resp_valid_o,
   output logic [RESP_W-1:0]  resp_o,
   output logic [NCHAL_W-1:0] resp_idx_o,
`ifdef PUF_SEQ_STABILITY_EN
   output logic [RESP_W-1:0]  unstable_o,
`endif
   puf_seq_if.master          puf
);

   localparam int TMO_W = $clog2(TMO_CYC + 1);

   puf_state_e         state_q, state_d;
   logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic               req_q, req_d, rv_q, rv_d;
   logic [RESP_W-1:0]  resp_q, resp_d;
   logic [31:0]        base_q, base_d, sel_q, sel_d;
   logic [NCHAL_W-1:0] num_q, num_d, idx_q, idx_d;
   logic [VOTE_W-1:0]  reps_q, reps_d, rep_cnt_q, rep_cnt_d;
   logic [3:0]         wait_q, wait_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               vote_clr, vote_acc;
   logic [RESP_W-1:0]  vote_maj;
`ifdef PUF_SEQ_STABILITY_EN
   logic [RESP_W-1:0]  vote_unst, unst_q, unst_d;
`endif

   puf_vote u_vote (
      .clk50      (clk50),
      .rstn_clk50 (rstn_clk50),
      .clr_i      (vote_clr),
      .acc_i      (vote_acc),
      .bits_i     (puf.puf_q_i),
      .reps_i     (reps_q),
`ifdef PUF_SEQ_STABILITY_EN
      .unstable_o (vote_unst),
`endif
      .maj_o      (vote_maj)
   );

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      req_d     = 1'b0;
      rv_d      = 1'b0;
      resp_d    = resp_q;
      base_d    = base_q;
      num_d     = num_q;
      reps_d    = reps_q;
      wait_d    = wait_q;
      idx_d     = idx_q;
      rep_cnt_d = rep_cnt_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      vote_clr  = 1'b0;
      vote_acc  = 1'b0;
`ifdef PUF_SEQ_STABILITY_EN
      unst_d    = unst_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               base_d    = base_sel_i;
               num_d     = num_chal_i;
               reps_d    = reps_i | 3'd1;
               wait_d    = wait_cyc_i;
               idx_d     = '0;
               rep_cnt_d = '0;
               retry_d   = '0;
               err_d     = 1'b0;
               vote_clr  = 1'b1;
               busy_d    = 1'b1;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!puf.puf_busy_i) begin
               req_d   = 1'b1;
               tmo_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A sample is trusted only when the q/qn rails are exact complements.
            if (puf.puf_valid_i) begin
               if (puf.puf_q_i == ~puf.puf_qn_i) begin
                  vote_acc  = 1'b1;
                  rep_cnt_d = rep_cnt_q + 3'd1;
                  state_d   = (rep_cnt_d == reps_q) ? ST_VOTE : ST_ISSUE;
               end else begin
                  retry_d = retry_q + 2'd1;
                  if (retry_d == RETRY_W'(RETRY_MAX)) begin
                     err_d   = 1'b1;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = ST_FIN;
                  end else begin
                     state_d = ST_ISSUE;
                  end
               end
            end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_FIN;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_VOTE: begin
            resp_d  = vote_maj;
`ifdef PUF_SEQ_STABILITY_EN
            unst_d  = vote_unst;
`endif
            rv_d    = 1'b1;
            state_d = ST_EMIT;
         end
         ST_EMIT: begin
            // num_q of zero wraps to all-ones here, giving the full 2**NCHAL_W run.
            if (idx_q == NCHAL_W'(num_q - 1'b1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_FIN;
            end else begin
               idx_d     = idx_q + 1'b1;
               rep_cnt_d = '0;
               retry_d   = '0;
               vote_clr  = 1'b1;
               state_d   = ST_ISSUE;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      sel_d = base_d + 32'(idx_d);
   end

   always_ff @(posedge clk50 or negedge rstn_clk50) begin
      if (!rstn_clk50) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         req_q     <= 1'b0;
         rv_q      <= 1'b0;
         resp_q    <= '0;
         base_q    <= '0;
         sel_q     <= '0;
         num_q     <= '0;
         idx_q     <= '0;
         reps_q    <= '0;
         rep_cnt_q <= '0;
         wait_q    <= '0;
         retry_q   <= '0;
         tmo_q     <= '0;
`ifdef PUF_SEQ_STABILITY_EN
         unst_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         req_q     <= req_d;
         rv_q      <= rv_d;
         resp_q    <= resp_d;
         base_q    <= base_d;
         sel_q     <= sel_d;
         num_q     <= num_d;
         idx_q     <= idx_d;
         reps_q    <= reps_d;
         rep_cnt_q <= rep_cnt_d;
         wait_q    <= wait_d;
         retry_q   <= retry_d;
         tmo_q     <= tmo_d;
`ifdef PUF_SEQ_STABILITY_EN
         unst_q    <= unst_d;
`endif
      end
   end

   assign busy_o             = busy_q;
   assign done_o             = done_q;
   assign err_o              = err_q;
   assign resp_valid_o       = rv_q;
   assign resp_o             = resp_q;
   assign resp_idx_o         = idx_q;
   assign puf.puf_req_o      = req_q;
   assign puf.puf_sel_o      = sel_q;
   assign puf.puf_wait_cyc_o = wait_q;
`ifdef PUF_SEQ_STABILITY_EN
   assign unstable_o         = unst_q;
`endif

endmodule

// File: tb/tb_puf_seq.sv
// Self-checking bench for puf_seq: directed scenarios plus randomized runs scored against
// a sample-list reference model. Checks unstable_o too when PUF_SEQ_STABILITY_EN is defined.
module tb_puf_seq;

   localparam int NCHAL_W = 4;
   localparam int TMO_CYC = 64;
`ifdef PUF_SEQ_STABILITY_EN
   localparam bit STAB = 1'b1;
`else
   localparam bit STAB = 1'b0;
`endif

   logic               clk50 = 1'b0;
   logic               rstn_clk50 = 1'b0;
   logic               start_i = 1'b0;
   logic [31:0]        base_sel_i = '0;
   logic [NCHAL_W-1:0] num_chal_i = '0;
   logic [2:0]         reps_i = '0;
   logic [3:0]         wait_cyc_i = '0;
   logic               busy_o, done_o, err_o, resp_valid_o;
   logic [5:0]         resp_o, unst;
   logic [NCHAL_W-1:0] resp_idx_o;
   logic [63:0]        all_outs;

   puf_seq_if puf_bus();

   puf_seq #(.NCHAL_W(NCHAL_W), .TMO_CYC(TMO_CYC)) dut (
      .clk50        (clk50),
      .rstn_clk50   (rstn_clk50),
      .start_i      (start_i),
      .base_sel_i   (base_sel_i),
      .num_chal_i   (num_chal_i),
      .reps_i       (reps_i),
      .wait_cyc_i   (wait_cyc_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .resp_valid_o (resp_valid_o),
      .resp_o       (resp_o),
      .resp_idx_o   (resp_idx_o),
`ifdef PUF_SEQ_STABILITY_EN
      .unstable_o   (unst),
`endif
      .puf          (puf_bus)
   );

`ifndef PUF_SEQ_STABILITY_EN
   assign unst = '0;
`endif

   assign all_outs = {7'd0, unst, busy_o, done_o, err_o, resp_valid_o, resp_o, resp_idx_o,
                      puf_bus.puf_req_o, puf_bus.puf_sel_o, puf_bus.puf_wait_cyc_o};

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit eng_silent = 1'b0;

   logic [11:0] stim_q[$];
   logic [11:0] eng_q[$];
   logic [31:0] mon_sel[$];
   logic [31:0] exp_sel[$];
   logic [15:0] mon_resp[$];
   logic [15:0] exp_resp[$];
   int          exp_err;
   int          mon_reqs, mon_done, mon_req_cyc, mon_rv_cyc, mon_done_cyc;
   logic        mon_done_busy;

   initial forever #5 clk50 = ~clk50;

   always @(posedge clk50) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Observes the DUT on the falling edge, away from the active edge.
   initial forever begin
      @(negedge clk50);
      if (puf_bus.puf_req_o) begin
         mon_sel.push_back(puf_bus.puf_sel_o);
         mon_reqs++;
         mon_req_cyc = cyc;
      end
      if (resp_valid_o) begin
         mon_resp.push_back({resp_idx_o, resp_o, unst});
         mon_rv_cyc = cyc;
      end
      if (done_o) begin
         mon_done++;
         mon_done_cyc = cyc;
         mon_done_busy = busy_o;
      end
   end

   // PUF engine: answers each request after a random delay with the next queued sample.
   initial begin : engine
      logic [11:0] s;
      int lat;
      puf_bus.puf_valid_i = 1'b0;
      puf_bus.puf_q_i = '0;
      puf_bus.puf_qn_i = '0;
      forever begin
         @(negedge clk50);
         if (puf_bus.puf_req_o && !eng_silent) begin
            lat = $urandom_range(0, 4);
            repeat (lat) @(negedge clk50);
            s = {6'h00, 6'h3F};
            if (eng_q.size() > 0) s = eng_q.pop_front();
            puf_bus.puf_valid_i = 1'b1;
            puf_bus.puf_q_i = s[11:6];
            puf_bus.puf_qn_i = s[5:0];
            @(negedge clk50);
            puf_bus.puf_valid_i = 1'b0;
         end
      end
   end

   function automatic logic [11:0] goodS(input logic [5:0] q);
      return {q, ~q};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Walks the sample list in order: each sample costs one request, good ones vote,
   // the third bad one for a challenge ends the run with an error.
   task automatic modelRun(input logic [31:0] base, input int nchal, input int eff);
      int pos, good, bad;
      int ones[6];
      logic [11:0] s;
      logic [5:0] maj, un;
      pos = 0;
      exp_err = 0;
      exp_sel.delete();
      exp_resp.delete();
      for (int c = 0; c < nchal && exp_err == 0; c++) begin
         good = 0;
         bad = 0;
         for (int i = 0; i < 6; i++) ones[i] = 0;
         while (good < eff && exp_err == 0 && pos < stim_q.size()) begin
            s = stim_q[pos];
            pos++;
            exp_sel.push_back(base + 32'(c));
            if (s[11:6] == ~s[5:0]) begin
               good++;
               for (int i = 0; i < 6; i++) if (s[6+i]) ones[i]++;
            end else begin
               bad++;
               if (bad == 3) exp_err = 1;
            end
         end
         if (exp_err == 0) begin
            for (int i = 0; i < 6; i++) begin
               maj[i] = (2 * ones[i]) > eff;
               un[i] = STAB && (ones[i] != 0) && (ones[i] != eff);
            end
            exp_resp.push_back({4'(c), maj, un});
         end
      end
   endtask

   task automatic genStim(input int nchal, input int eff);
      int good;
      logic [5:0] q;
      stim_q.delete();
      for (int c = 0; c < nchal; c++) begin
         good = 0;
         while (good < eff) begin
            q = 6'($urandom);
            if ($urandom_range(0, 5) == 0) begin
               stim_q.push_back({q, ~q ^ 6'($urandom_range(1, 63))});
            end else begin
               stim_q.push_back(goodS(q));
               good++;
            end
         end
      end
   endtask

   task automatic startRun(input logic [31:0] base, input logic [NCHAL_W-1:0] num,
                           input logic [2:0] reps, input logic [3:0] waitc);
      mon_sel.delete();
      mon_resp.delete();
      mon_reqs = 0;
      mon_done = 0;
      eng_q = stim_q;
      @(negedge clk50);
      base_sel_i = base;
      num_chal_i = num;
      reps_i = reps;
      wait_cyc_i = waitc;
      start_i = 1'b1;
      @(negedge clk50);
      start_i = 1'b0;
      checkOutput("busy_after_start", busy_o, 1);
   endtask

   task automatic waitDone(input int limit);
      int n;
      n = 0;
      while (mon_done == 0 && n < limit) begin
         @(negedge clk50);
         n++;
      end
      checkOutput("done_seen", mon_done != 0, 1);
      repeat (3) @(negedge clk50);
   endtask

   task automatic applyStimulus(input logic [31:0] base, input logic [NCHAL_W-1:0] num,
                                input logic [2:0] reps, input logic [3:0] waitc);
      startRun(base, num, reps, waitc);
      waitDone(3000);
   endtask

   task automatic compareRun(input logic [3:0] waitc);
      checkOutput("err", err_o, exp_err);
      checkOutput("req_count", mon_reqs, exp_sel.size());
      checkOutput("resp_count", mon_resp.size(), exp_resp.size());
      for (int i = 0; i < mon_sel.size() && i < exp_sel.size(); i++)
         checkOutput($sformatf("sel[%0d]", i), mon_sel[i], exp_sel[i]);
      for (int i = 0; i < mon_resp.size() && i < exp_resp.size(); i++)
         checkOutput($sformatf("idx_resp_unst[%0d]", i), mon_resp[i], exp_resp[i]);
      checkOutput("done_pulses", mon_done, 1);
      checkOutput("busy_at_done", mon_done_busy, 0);
      checkOutput("wait_cyc", puf_bus.puf_wait_cyc_o, waitc);
      if (exp_err == 0 && exp_resp.size() > 0)
         checkOutput("done_after_resp", mon_done_cyc - mon_rv_cyc, 1);
   endtask

   task automatic runCase(input logic [31:0] base, input logic [NCHAL_W-1:0] num,
                          input logic [2:0] reps, input logic [3:0] waitc);
      modelRun(base, (num == 0) ? 16 : int'(num), int'(reps | 3'd1));
      applyStimulus(base, num, reps, waitc);
      compareRun(waitc);
   endtask

   initial begin
      int n, rel_cyc, nch;
      logic [31:0] base;
      logic [2:0] reps;
      logic [3:0] waitc;

      puf_bus.puf_busy_i = 1'b0;
      repeat (2) @(negedge clk50);
      checkOutput("reset_outputs", all_outs, 0);
      rstn_clk50 = 1'b1;
      repeat (2) @(negedge clk50);

      stim_q = '{goodS(6'h2A)};
      runCase(32'h0000_0010, 4'd1, 3'd0, 4'h5);
      checkOutput("single_resp", resp_o, 6'h2A);

      stim_q = '{goodS(6'h3F), goodS(6'h00), goodS(6'h3F)};
      runCase(32'h0000_0100, 4'd1, 3'd2, 4'h1);
      checkOutput("majority_resp", resp_o, 6'h3F);
`ifdef PUF_SEQ_STABILITY_EN
      checkOutput("majority_unstable", unst, 6'h3F);
`endif

      stim_q.delete();
      for (int i = 0; i < 16; i++) stim_q.push_back(goodS(6'($urandom)));
      runCase(32'hFFFF_FFFF, 4'd0, 3'd0, 4'hA);
      checkOutput("wrap_sel1", (mon_sel.size() > 1) ? mon_sel[1] : 32'hDEAD_BEEF, 32'h0);

      stim_q = '{{6'h01, 6'h01}, {6'h01, 6'h01}, {6'h01, 6'h01}};
      runCase(32'h0000_0200, 4'd2, 3'd0, 4'h2);

      stim_q = '{{6'h01, 6'h01}, goodS(6'h2C)};
      runCase(32'h0000_0300, 4'd1, 3'd0, 4'h2);

      stim_q.delete();
      eng_silent = 1'b1;
      puf_bus.puf_busy_i = 1'b1;
      startRun(32'hABCD_0000, 4'd1, 3'd0, 4'h3);
      repeat (9) @(negedge clk50);
      checkOutput("bp_no_req", mon_reqs, 0);
      rel_cyc = cyc;
      puf_bus.puf_busy_i = 1'b0;
      waitDone(300);
      checkOutput("bp_req_count", mon_reqs, 1);
      checkOutput("bp_req_after_release", (mon_req_cyc > rel_cyc) && (mon_req_cyc <= rel_cyc + 2), 1);
      checkOutput("tmo_latency", mon_done_cyc - mon_req_cyc, TMO_CYC);
      checkOutput("tmo_err", err_o, 1);
      checkOutput("tmo_no_resp", mon_resp.size(), 0);

      startRun(32'h1234_5678, 4'd3, 3'd2, 4'h9);
      n = 0;
      while (mon_reqs == 0 && n < 50) begin
         @(negedge clk50);
         n++;
      end
      checkOutput("rst_reached_wait", mon_reqs, 1);
      @(negedge clk50);
      rstn_clk50 = 1'b0;
      #1;
      checkOutput("rst_outputs_zero", all_outs, 0);
      mon_done = 0;
      repeat (5) @(negedge clk50);
      checkOutput("rst_no_done", mon_done, 0);
      rstn_clk50 = 1'b1;
      eng_silent = 1'b0;
      stim_q = '{goodS(6'h15)};
      runCase(32'h0000_0040, 4'd1, 3'd0, 4'h4);

      for (int r = 0; r < 6; r++) begin
         base = $urandom;
         nch = $urandom_range(1, 5);
         reps = 3'($urandom_range(0, 7));
         waitc = 4'($urandom);
         genStim(nch, int'(reps | 3'd1));
         runCase(base, NCHAL_W'(nch), reps, waitc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/puf_seq.md
PUF_SEQ -- requirements
Module: puf_seq

Interface
REQ-001 Parameter NCHAL_W, default 4: width of challenge index; up to 2**NCHAL_W challenges per run.
REQ-002 Parameter TMO_CYC, default 64: clk50 cycles allowed from puf_req_o to puf_valid_i before timeout.
REQ-003 clk50  in  1  sole clock; all ports synchronous to its rising edge.
REQ-004 rstn_clk50  in  1  reset, asynchronous assert, active-low.
REQ-005 start_i  in  1  single-cycle run request; honoured only when busy_o=0.
REQ-006 base_sel_i  in  32  base challenge; captured at accepted start_i.
REQ-007 num_chal_i  in  NCHAL_W  challenges per run; 0 means 2**NCHAL_W.
REQ-008 reps_i  in  3  evaluations per challenge; effective value is reps_i|1, giving 1,3,5,7.
REQ-009 wait_cyc_i  in  4  PUF settle setting; captured at start_i, driven on puf_wait_cyc_o.
REQ-010 busy_o  out  1  run in progress.
REQ-011 done_o  out  1  one-cycle pulse at run end.
REQ-012 err_o  out  1  sticky error for current/last run; cleared at next accepted start_i.
REQ-013 resp_valid_o  out  1  one-cycle pulse qualifying resp_o and resp_idx_o.
REQ-014 resp_o  out  6  majority-voted response.
REQ-015 resp_idx_o  out  NCHAL_W  challenge index of resp_o.
REQ-016 puf_req_o  out  1  single-cycle request to the PUF engine.
REQ-017 puf_sel_o  out  32  challenge; held stable from puf_req_o until puf_valid_i.
REQ-018 puf_wait_cyc_o  out  4  registered copy of wait_cyc_i.
REQ-019 puf_busy_i, puf_valid_i  in  1 each  PUF engine busy level and result-valid pulse.
REQ-020 puf_q_i, puf_qn_i  in  6 each  PUF result pair; sampled only when puf_valid_i=1.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, VOTE, EMIT, FIN.
REQ-022 IDLE->ISSUE on start_i: captures inputs, clears index, vote counters, retry count and err_o; asserts busy_o from the next cycle.
REQ-023 ISSUE: puf_req_o=1 for exactly one cycle, only while puf_busy_i=0; otherwise stays in ISSUE. Next state is WAIT.
REQ-024 puf_sel_o = base_sel + index, computed modulo 2**32.
REQ-025 WAIT on puf_valid_i with puf_q_i == ~puf_qn_i: add each q bit to its 3-bit vote counter and increment rep count. Then VOTE if rep count equals effective reps, else ISSUE.
REQ-026 WAIT on puf_valid_i with complementarity mismatch: discard the sample and increment retry count. Return to ISSUE while retries < 3. At the 3rd mismatch for one challenge, set err_o and go to FIN.
REQ-027 WAIT timeout: TMO_CYC cycles without puf_valid_i sets err_o and goes to FIN.
REQ-028 VOTE, one cycle: resp bit = 1 iff 2*count > effective reps.
REQ-029 EMIT, one cycle: resp_valid_o=1. Then go to FIN if index = num_chal-1. Otherwise increment index, clear counters and retries, and go to ISSUE.
REQ-030 FIN, one cycle: done_o=1 and busy_o deasserts in the same cycle; next state IDLE.
REQ-031 start_i while busy_o=1 is ignored.
REQ-032 puf_valid_i outside WAIT is ignored.

Reset
REQ-033 On reset assertion: state IDLE; all outputs 0; counters, index and captured registers 0.
REQ-034 Reset mid-run aborts the run with no done_o. The first start_i after deassertion begins a fresh run.

Configuration
REQ-035 Macro PUF_SEQ_STABILITY_EN.
  - Defined: adds output unstable_o[5:0], valid with resp_valid_o, with bit i=1 iff vote counter i is neither 0 nor the effective reps.
  - Undefined: no port, no logic.

Structure
REQ-036 Shared package puf_pkg holds: the FSM state enumeration, the retry limit constant (3), and the vote-counter width (3).
REQ-037 One sub-module, puf_vote: six vote counters plus the majority/stability compare, with clear, accumulate and effective-reps inputs.

Verification
REQ-038 Single challenge: base_sel=0x0000_0010, num_chal=1, reps_i=0; model returns q=0x2A, qn=0x15. Required: one puf_req_o, resp_o=0x2A, resp_idx_o=0, done_o one cycle after resp_valid_o.
REQ-039 Majority: reps_i=2 (3 evals); model returns 0x3F, 0x00, 0x3F. Required: resp_o=0x3F. With STABILITY_EN, unstable_o=0x3F.
REQ-040 Sequence: num_chal=0, NCHAL_W=4. Required: 16 responses, idx 0..15, puf_sel_o base..base+15. Base 0xFFFF_FFFF wraps to 0x0000_0000 at idx 1.
REQ-041 Mismatch: model returns q=qn=0x01 three times. Required: 3 puf_req_o, err_o=1, done_o, no resp_valid_o. A single mismatch followed by a good sample is retried with no error.
REQ-042 Timeout/back-pressure: puf_busy_i held high for 10 cycles delays puf_req_o. With puf_valid_i never returned, err_o and done_o assert 64 cycles after puf_req_o.
REQ-043 Reset: rstn_clk50 low during WAIT. Required: all outputs 0 immediately, no done_o, and a subsequent run completes normally.
